// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: single-cycle primary write-back shares the port
// with a small in-order FIFO of multi-cycle results, with newer-write-wins kill bits.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pri_valid,
  input  logic [4:0]  pri_rd,
  input  logic [31:0] pri_data,
  output logic        pri_stall,
  input  logic        sec_valid,
  input  logic [4:0]  sec_rd,
  input  logic [31:0] sec_data,
  output logic        sec_ready,
  input  logic [4:0]  probe_rd,
  output logic        pend_hit,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] kill_reg;
  logic [DEPTH-1:0] kill_next;
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [3:0]       wait_cnt_reg;
  logic [3:0]       wait_cnt_next;
  logic [0:0]       state_reg;
  logic [0:0]       state_next;

  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             head_kill;
  logic             head_live;
  logic [4:0]       head_rd;
  logic [31:0]      head_data;
  logic             pri_req;
  logic             force_now;
  logic             pri_grant;
  logic             head_grant;
  logic             pop;
  logic             push;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] probe_match;
  logic [DEPTH-1:0] pri_match;

  assign wr_idx    = wr_ptr_reg[AW-1:0];
  assign rd_idx    = rd_ptr_reg[AW-1:0];
  assign count     = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
  assign head_kill = kill_reg[rd_idx];
  assign head_rd   = rd_mem[rd_idx];
  assign head_data = data_mem[rd_idx];
  assign head_live = !empty && !head_kill;

  // x0 writes are architecturally discarded, so they never compete for the port.
  assign pri_req    = pri_valid && (pri_rd != 5'd0);
  // A forced slot whose head was killed meanwhile degrades to normal arbitration.
  assign force_now  = (state_reg == ST_FORCE) && head_live;
  assign pri_grant  = pri_req && !force_now;
  assign head_grant = head_live && !pri_grant;
  assign pop        = head_grant || (!empty && head_kill);
  assign push       = sec_valid && !full && (sec_rd != 5'd0);

  // Per-slot occupancy, probe lookup and kill update.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs           = AW'(gi) - rd_idx;
    assign occ[gi]        = ({1'b0, offs} < count);
    assign probe_match[gi] = occ[gi] && !kill_reg[gi] && (rd_mem[gi] == probe_rd);
    assign pri_match[gi]  = occ[gi] && (rd_mem[gi] == pri_rd);

    always_comb begin
      kill_next[gi] = kill_reg[gi];
      if (push && (wr_idx == AW'(gi))) begin
        kill_next[gi] = 1'b0;
      end else if (pri_grant && pri_match[gi]) begin
        kill_next[gi] = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (pop || empty) begin
      wait_cnt_next = 4'd0;
    end else if (head_live && pri_grant && (wait_cnt_reg < LIMIT)) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  always_comb begin
    state_next = ST_NORMAL;
    if ((state_reg == ST_NORMAL) && (wait_cnt_next == LIMIT)) begin
      state_next = ST_FORCE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      kill_reg     <= '0;
      wait_cnt_reg <= 4'd0;
      state_reg    <= ST_NORMAL;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      kill_reg     <= kill_next;
      wait_cnt_reg <= wait_cnt_next;
      state_reg    <= state_next;
    end
  end

  // Payload storage needs no reset: occupancy is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_idx]   <= sec_rd;
      data_mem[wr_idx] <= sec_data;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = 5'd0;
    rf_wdata = 32'd0;
    if (!rst) begin
      if (pri_grant) begin
        rf_we    = 1'b1;
        rf_rd    = pri_rd;
        rf_wdata = pri_data;
      end else if (head_grant) begin
        rf_we    = 1'b1;
        rf_rd    = head_rd;
        rf_wdata = head_data;
      end
    end
  end

  assign sec_ready = !rst && !full;
  assign pri_stall = !rst && pri_req && force_now;
  assign pend_hit  = !rst && (probe_rd != 5'd0) && (|probe_match);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pri_valid = 1'b0;
  logic [4:0]  pri_rd = 5'd0;
  logic [31:0] pri_data = 32'd0;
  logic        pri_stall;
  logic        sec_valid = 1'b0;
  logic [4:0]  sec_rd = 5'd0;
  logic [31:0] sec_data = 32'd0;
  logic        sec_ready;
  logic [4:0]  probe_rd = 5'd0;
  logic        pend_hit;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pri_valid(pri_valid), .pri_rd(pri_rd), .pri_data(pri_data), .pri_stall(pri_stall),
    .sec_valid(sec_valid), .sec_rd(sec_rd), .sec_data(sec_data), .sec_ready(sec_ready),
    .probe_rd(probe_rd), .pend_hit(pend_hit),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        kill;
  } ent_t;

  ent_t q[$];
  int   mwait = 0;
  bit   mforce = 1'b0;
  bit   m_valid = 1'b0;
  bit   e_pri, e_head, e_pop, e_ready, s_hlive, s_sec_valid;
  logic [4:0]  s_pri_rd, s_sec_rd;
  logic [31:0] s_sec_data;
  logic [31:0] dut_rf [32];

  initial for (int i = 0; i < 32; i++) dut_rf[i] = 32'd0;

  always @(negedge clk) begin
    if (!rst && rf_we) dut_rf[rf_rd] = rf_wdata;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      chk("rst_we", rf_we, 0);
      chk("rst_rd", rf_rd, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_ready", sec_ready, 0);
      chk("rst_stall", pri_stall, 0);
      chk("rst_pend", pend_hit, 0);
    end else begin
      bit preq, fhead, pend;
      logic [4:0]  x_rd;
      logic [31:0] x_data;
      preq    = pri_valid && (pri_rd != 0);
      s_hlive = (q.size() > 0) && !q[0].kill;
      fhead   = mforce && s_hlive;
      e_pri   = preq && !fhead;
      e_head  = s_hlive && !e_pri;
      e_pop   = e_head || ((q.size() > 0) && q[0].kill);
      e_ready = (q.size() < DEPTH);
      pend = 1'b0;
      foreach (q[i]) if (probe_rd != 0 && q[i].rd == probe_rd && !q[i].kill) pend = 1'b1;
      x_rd = 5'd0;
      x_data = 32'd0;
      if (e_pri) begin
        x_rd = pri_rd; x_data = pri_data;
      end else if (e_head) begin
        x_rd = q[0].rd; x_data = q[0].data;
      end
      chk("m_we", rf_we, e_pri || e_head);
      chk("m_rd", rf_rd, x_rd);
      chk("m_wdata", rf_wdata, x_data);
      chk("m_ready", sec_ready, e_ready);
      chk("m_stall", pri_stall, preq && fhead);
      chk("m_pend", pend_hit, pend);
      s_pri_rd    = pri_rd;
      s_sec_valid = sec_valid;
      s_sec_rd    = sec_rd;
      s_sec_data  = sec_data;
      m_valid     = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mwait  = 0;
      mforce = 1'b0;
    end else if (m_valid) begin
      ent_t n;
      if (e_pri) foreach (q[i]) if (q[i].rd == s_pri_rd) q[i].kill = 1'b1;
      if (s_hlive && e_pri && mwait < LIMIT) mwait++;
      if (e_pop) void'(q.pop_front());
      if (s_sec_valid && e_ready && s_sec_rd != 0) begin
        n.rd = s_sec_rd; n.data = s_sec_data; n.kill = 1'b0;
        q.push_back(n);
      end
      if (e_pop || q.size() == 0) mwait = 0;
      mforce = !mforce && (mwait == LIMIT);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pri(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pri_valid = v; pri_rd = rd; pri_data = d;
  endtask

  task automatic sec(input logic v, input logic [4:0] rd, input logic [31:0] d);
    sec_valid = v; sec_rd = rd; sec_data = d;
  endtask

  int exp_rd_t2 [6] = '{3, 3, 3, 3, 7, 3};
  int exp_st_t2 [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    // reset holds every output low even with requests present
    pri(1, 5'd3, 32'h33);
    sec(1, 5'd4, 32'h44);
    #2;
    chk("reset_we", rf_we, 0);
    chk("reset_ready", sec_ready, 0);
    chk("reset_stall", pri_stall, 0);
    pri(0, 0, 0); sec(0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;

    // idle
    @(negedge clk);
    chk("idle_we", rf_we, 0);
    chk("idle_ready", sec_ready, 1);
    chk("idle_pend", pend_hit, 0);
    cyc();

    // single secondary push, written next cycle
    sec(1, 5'd5, 32'hAAAA0005);
    @(negedge clk); chk("t1_push_we", rf_we, 0);
    cyc();
    sec(0, 0, 0); probe_rd = 5'd5;
    @(negedge clk);
    chk("t1_we", rf_we, 1); chk("t1_rd", rf_rd, 5); chk("t1_data", rf_wdata, 32'hAAAA0005);
    chk("t1_pend", pend_hit, 1);
    cyc();
    @(negedge clk); chk("t1_empty_we", rf_we, 0); chk("t1_empty_pend", pend_hit, 0);
    cyc();

    // starvation: head forced through on the 5th primary cycle
    sec(1, 5'd7, 32'h77);
    @(negedge clk); chk("t2_push_we", rf_we, 0);
    cyc();
    sec(0, 0, 0); pri(1, 5'd3, 32'h33);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2_rd%0d", k), rf_rd, exp_rd_t2[k]);
      chk($sformatf("t2_stall%0d", k), pri_stall, exp_st_t2[k]);
      cyc();
    end

    // kill: newer primary write to x9 supersedes the buffered one
    sec(1, 5'd9, 32'h99);
    @(negedge clk); chk("t3_a_rd", rf_rd, 3);
    cyc();
    sec(0, 0, 0); pri(1, 5'd9, 32'h11); probe_rd = 5'd9;
    @(negedge clk);
    chk("t3_pend_before", pend_hit, 1); chk("t3_rd", rf_rd, 9); chk("t3_data", rf_wdata, 32'h11);
    cyc();
    pri(0, 0, 0);
    @(negedge clk); chk("t3_pend_after", pend_hit, 0); chk("t3_silent_pop", rf_we, 0);
    cyc();
    @(negedge clk); chk("t3_idle_we", rf_we, 0); chk("t3_ready", sec_ready, 1);
    cyc();

    // fill while primary busy; third offer held until a pop
    pri(1, 5'd4, 32'h44);
    sec(1, 5'd10, 32'hA);
    @(negedge clk); chk("t4_a_ready", sec_ready, 1);
    cyc();
    sec(1, 5'd11, 32'hB);
    @(negedge clk); chk("t4_b_ready", sec_ready, 1); chk("t4_b_rd", rf_rd, 4);
    cyc();
    sec(1, 5'd12, 32'hC);
    @(negedge clk); chk("t4_full_ready", sec_ready, 0);
    cyc();
    pri(0, 0, 0);
    @(negedge clk); chk("t4_d_rd", rf_rd, 10); chk("t4_d_ready", sec_ready, 0);
    cyc();
    @(negedge clk); chk("t4_e_rd", rf_rd, 11); chk("t4_e_ready", sec_ready, 1);
    cyc();
    sec(0, 0, 0);
    @(negedge clk); chk("t4_f_rd", rf_rd, 12); chk("t4_f_data", rf_wdata, 32'hC);
    cyc();
    @(negedge clk); chk("t4_g_we", rf_we, 0);
    cyc();

    // reset mid-run with two buffered entries
    pri(1, 5'd4, 32'h44);
    sec(1, 5'd13, 32'hD);
    cyc();
    sec(1, 5'd14, 32'hE);
    cyc();
    sec(0, 0, 0); probe_rd = 5'd13;
    @(negedge clk); chk("t5_pend", pend_hit, 1); chk("t5_ready", sec_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_we", rf_we, 0); chk("t5_rst_rd", rf_rd, 0); chk("t5_rst_pend", pend_hit, 0);
    chk("t5_rst_ready", sec_ready, 0); chk("t5_rst_stall", pri_stall, 0);
    cyc(); cyc();
    rst = 1'b0; pri(0, 0, 0);
    @(negedge clk); chk("t5_post_we", rf_we, 0); chk("t5_post_pend", pend_hit, 0);
    chk("t5_post_ready", sec_ready, 1);
    cyc(); cyc(); cyc();

    // x0 requests: secondary handshake completes but nothing stored; primary never stalls
    sec(1, 5'd0, 32'hDEAD);
    @(negedge clk); chk("t6_ready", sec_ready, 1);
    cyc();
    sec(0, 0, 0); pri(1, 5'd0, 32'hBEEF);
    @(negedge clk); chk("t6_we", rf_we, 0); chk("t6_stall", pri_stall, 0);
    cyc();
    pri(0, 0, 0);
    cyc();

    // final architectural register contents as seen through the write port
    chk("rf_x5", dut_rf[5], 32'hAAAA0005);
    chk("rf_x7", dut_rf[7], 32'h77);
    chk("rf_x9", dut_rf[9], 32'h11);
    chk("rf_x10", dut_rf[10], 32'hA);
    chk("rf_x11", dut_rf[11], 32'hB);
    chk("rf_x12", dut_rf[12], 32'hC);
    chk("rf_x13", dut_rf[13], 32'h0);
    chk("rf_x14", dut_rf[14], 32'h0);
    chk("rf_x0", dut_rf[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
